inst_fetch_buffer: RTL and testbench
====================================

// Module: inst_fetch_buffer
// PURPOSE
//  Upstream fetch stage for the riscvcpu core. Issues sequential word fetches on a valid/ready
//  instruction-memory bus and buffers the returned instructions in a small FIFO. Presents them,
//  with their PCs, to the core over a valid/ready decode interface. A redirect input (taken
//  branch, jump or trap) flushes the buffer and restarts fetch at a new PC.
// PARAMETERS
//  DEPTH     4             FIFO entries; also the maximum number of outstanding requests (>=2)
//  RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
//  clk             in   1   clock; all state changes on the rising edge
//  rst             in   1   asynchronous reset, active-low
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts the request this cycle
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response valid; returns in order; no backpressure
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   flush the buffer and restart fetch at redirect_pc
//  redirect_pc     in   32  new PC; bits [1:0] are ignored and treated as 0
//  inst_valid      out  1   inst_data/inst_pc hold a valid instruction
//  inst_ready      in   1   core consumes the instruction (transfer = inst_valid & inst_ready)
//  inst_data       out  32  instruction word
//  inst_pc         out  32  PC of inst_data
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
//   - imem_req_valid=0, inst_valid=0. inst_data and inst_pc read 0.
//  Issue:
//   - imem_req_valid = !redirect_valid & (fifo_count + outstanding < DEPTH). imem_req_addr = fetch_pc.
//   - Once raised, the request is held with a stable address until ready is seen. The only
//     exception is a redirect, which may withdraw it.
//   - On a request handshake: fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
//   - Each request's PC is pushed to a PC-tag queue of depth DEPTH.
//  Response:
//   - Each rsp decrements outstanding and pops one PC tag.
//   - If drop_cnt>0, the rsp is discarded and drop_cnt decrements.
//   - Otherwise {tag, data} is written into the FIFO.
//   - Counters are $clog2(DEPTH+1) bits wide. The credit rule guarantees no overflow.
//   - A rsp with outstanding==0 is a protocol error: assertion only, no other effect.
//  Output:
//   - inst_valid = FIFO non-empty. A rsp written to the FIFO appears on inst_valid at cycle N+1.
//   - A push and a pop in the same cycle are legal at any fill level, including full.
//  Redirect (redirect_valid=1, single cycle, highest priority):
//   - FIFO is cleared. fetch_pc <= {redirect_pc[31:2],2'b00}. No request is issued that cycle.
//   - drop_cnt <= outstanding after this cycle's rsp is accounted. A rsp arriving this same
//     cycle is itself discarded.
//   - An inst_ready transfer in the redirect cycle still completes. The core ignores it.
//   - Fetch resumes at the new PC the next cycle, subject to credits. Tags keep order.
//  Simultaneous redirect and drop_cnt>0: drop_cnt is reloaded to the new value. It does not
//   accumulate, because outstanding already counts the older requests.
//  Reset mid-operation: all in-flight responses are forgotten. The memory side must also be
//   reset by the same rst.
// CONFIGURATION
//  IFB_BYPASS_EN defined:
//   - When the FIFO is empty and a non-dropped rsp arrives, inst_valid=1 in the same cycle,
//     with data and PC taken from the rsp and tag.
//   - If inst_ready=1, the entry is not written (zero-latency path).
//   - If inst_ready=0, it is written and presented from the FIFO next cycle.
//   - Credits are unchanged.
//  IFB_BYPASS_EN undefined: the one-cycle registered latency described above applies.
// STRUCTURE
//  - Shared package fetch_pkg holds: the XLEN=32 constant, the RESET_PC default, and the
//    fetch_entry_t {pc[31:0], inst[31:0]} typedef. The package is reused by later decode and
//    trap logic.
//  - Sub-module ifb_fifo is a synchronous DEPTH-entry FIFO with flush, count, full and empty.
//    It is instantiated twice: once as the entry FIFO (fetch_entry_t) and once as the PC-tag
//    queue (32b).
//  - The top level holds fetch_pc, the outstanding and drop counters, and the bypass mux.
// TESTING
//  1 Reset release with imem_req_ready=1 and 1-cycle rsp latency:
//    - Addresses 0x80000000, 0x80000004, ... are issued.
//    - inst_pc follows the same sequence and inst_data matches memory.
//  2 inst_ready=0 held:
//    - Exactly 4 requests are issued, then imem_req_valid=0.
//    - Raising inst_ready drains 4 entries in order, and issue resumes.
//  3 Two requests outstanding with 3-cycle rsp latency, then redirect to 0x80000100:
//    - Both stale rsps are dropped.
//    - The first inst_pc seen afterwards is 0x80000100.
//  4 Redirect in the same cycle as a rsp, plus redirect_pc=0x80000102:
//    - That rsp is discarded.
//    - The next imem_req_addr is 0x80000100.
//  5 fetch_pc=0xFFFFFFFC: the next request address wraps to 0x00000000.
//  6 With IFB_BYPASS_EN defined, FIFO empty and inst_ready=1:
//    - The rsp appears on inst_valid the same cycle and FIFO count stays 0.
//    - Without IFB_BYPASS_EN, it appears one cycle later.
//  Rst asserted mid-burst: all outputs are 0 immediately, asynchronously. Restart is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: word size, reset PC and the {pc, inst} entry type.
// Reused by the fetch buffer and later decode/trap logic.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifb_checker.sv
// Protocol and bookkeeping assertions for inst_fetch_buffer; no functional effect.
// A response with nothing outstanding is flagged here and otherwise ignored by the datapath.
module ifb_checker #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          rsp_valid_i,
  input logic [CW-1:0] out_cnt_i,
  input logic [CW-1:0] tag_count_i,
  input logic          tag_empty_i,
  input logic          tag_push_i,
  input logic          tag_full_i,
  input logic          ent_push_i,
  input logic          ent_pop_i,
  input logic          ent_full_i
);

  always @(posedge clk) begin
    if (rst) begin
      if (rsp_valid_i) assert (out_cnt_i != '0);
      assert (tag_count_i == out_cnt_i);
      assert ((out_cnt_i == '0) == tag_empty_i);
      assert (!(tag_push_i && tag_full_i));
      assert (!(ent_push_i && ent_full_i && !ent_pop_i));
    end
  end

endmodule

// File: rtl/ifb_fifo.sv
// Synchronous DEPTH-entry FIFO with flush, occupancy count, full and empty.
// A push and a pop may happen in the same cycle at any fill level, including full.
module ifb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop_s  = pop_i & !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push_s = push_i & (!full_o | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Sequential instruction fetch with credit-limited issue, in-order PC tagging, buffered
// delivery to decode and redirect flush. Define IFB_BYPASS_EN for the zero-latency empty-FIFO path.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            credit_ok_s, req_valid_s, req_fire_s;
  logic            rsp_acc_s, rsp_keep_s, byp_s;
  fetch_entry_t    rsp_entry_s, ent_rdata_s, out_entry_s;
  logic            ent_push_s, ent_pop_s, ent_full_s, ent_empty_s;
  logic [CW-1:0]   ent_count_s;
  logic [XLEN-1:0] tag_rdata_s;
  logic            tag_push_s, tag_pop_s, tag_full_s, tag_empty_s;
  logic [CW-1:0]   tag_count_s;

  // Issue, response accounting and output selection.
  always_comb begin
    credit_ok_s = ({1'b0, ent_count_s} + {1'b0, out_cnt_q}) < (CW + 1)'(DEPTH);
    req_valid_s = run_q & !redirect_valid & credit_ok_s;
    req_fire_s  = req_valid_s & imem_req_ready;
    rsp_acc_s   = imem_rsp_valid & (out_cnt_q != '0);
    rsp_keep_s  = rsp_acc_s & (drop_cnt_q == '0) & !redirect_valid;
    rsp_entry_s = '{pc: tag_rdata_s, inst: imem_rsp_data};
`ifdef IFB_BYPASS_EN
    byp_s       = ent_empty_s & rsp_keep_s;
`else
    byp_s       = 1'b0;
`endif
    out_entry_s = '0;
    if (!ent_empty_s) begin
      out_entry_s = ent_rdata_s;
    end else if (byp_s) begin
      out_entry_s = rsp_entry_s;
    end else begin
      out_entry_s = '0;
    end
    ent_pop_s  = !ent_empty_s & inst_ready;
    // A bypassed response that the core takes immediately never occupies the FIFO.
    ent_push_s = rsp_keep_s & !(byp_s & inst_ready);
    tag_push_s = req_fire_s;
    tag_pop_s  = rsp_acc_s;
  end

  // Next-state for fetch PC, outstanding and drop counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_cnt_d  = out_cnt_q + CW'(req_fire_s) - CW'(rsp_acc_s);
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      // Everything still in flight is stale; outstanding already covers older drops.
      drop_cnt_d = out_cnt_q - CW'(rsp_acc_s);
    end else begin
      fetch_pc_d = req_fire_s ? fetch_pc_q + 32'd4 : fetch_pc_q;
      drop_cnt_d = (rsp_acc_s && drop_cnt_q != '0) ? drop_cnt_q - CW'(1) : drop_cnt_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = !ent_empty_s | byp_s;
  assign inst_data      = out_entry_s.inst;
  assign inst_pc        = out_entry_s.pc;

  ifb_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ent_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (ent_push_s),
    .wdata_i (rsp_entry_s),
    .pop_i   (ent_pop_s),
    .rdata_o (ent_rdata_s),
    .count_o (ent_count_s),
    .full_o  (ent_full_s),
    .empty_o (ent_empty_s)
  );

  ifb_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (tag_push_s),
    .wdata_i (fetch_pc_q),
    .pop_i   (tag_pop_s),
    .rdata_o (tag_rdata_s),
    .count_o (tag_count_s),
    .full_o  (tag_full_s),
    .empty_o (tag_empty_s)
  );

  ifb_checker #(.CW(CW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .rsp_valid_i (imem_rsp_valid),
    .out_cnt_i   (out_cnt_q),
    .tag_count_i (tag_count_s),
    .tag_empty_i (tag_empty_s),
    .tag_push_i  (tag_push_s),
    .tag_full_i  (tag_full_s),
    .ent_push_i  (ent_push_s),
    .ent_pop_i   (ent_pop_s),
    .ent_full_i  (ent_full_s)
  );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: in-order memory model plus an expected
// instruction-stream model (next PC to deliver, next PC to request).
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef IFB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  typedef struct { int due; logic [31:0] addr; } pend_t;
  pend_t pend_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, lat = 1, hs_cnt = 0, xfer_cnt = 0;
  logic [31:0] exp_pc, exp_req_pc, prev_addr, obs_hs_addr, obs_xfer_pc;
  logic drv_req_rdy = 1'b0, drv_inst_rdy = 1'b0, drv_redir = 1'b0;
  logic [31:0] drv_redir_pc = 32'h0;
  logic obs_hs, obs_xfer, obs_rsp, obs_inst_valid, prev_pending;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_pc = RPC;
    exp_req_pc = RPC;
    prev_pending = 1'b0;
  endtask

  // One bus cycle: drive at negedge, sample 1ns later, update the model before the posedge.
  task automatic step();
    pend_t p;
    @(negedge clk);
    obs_rsp = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    imem_rsp_valid = obs_rsp;
    imem_rsp_data  = obs_rsp ? mem_word(pend_q[0].addr) : 32'h0;
    imem_req_ready = drv_req_rdy;
    inst_ready     = drv_inst_rdy;
    redirect_valid = drv_redir;
    redirect_pc    = drv_redir_pc;
    #1;
    obs_hs = imem_req_valid & imem_req_ready;
    obs_hs_addr = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_xfer = inst_valid & inst_ready;
    obs_xfer_pc = inst_pc;
    if (prev_pending && !drv_redir) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (drv_redir) chk("req_in_redirect", 32'(imem_req_valid), 32'd0);
    if (obs_hs) begin
      chk("req_addr", imem_req_addr, exp_req_pc);
      p.addr = imem_req_addr;
      p.due = cyc + lat;
      if (pend_q.size() > 0 && pend_q[$].due >= p.due) p.due = pend_q[$].due + 1;
      pend_q.push_back(p);
      chk("outstanding_le_depth", 32'(pend_q.size() <= DEPTH), 32'd1);
      exp_req_pc = exp_req_pc + 32'd4;
      hs_cnt++;
    end
    if (obs_xfer) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      xfer_cnt++;
    end
    if (drv_redir) begin
      exp_pc = {drv_redir_pc[31:2], 2'b00};
      exp_req_pc = exp_pc;
    end
    prev_pending = imem_req_valid & !imem_req_ready & !drv_redir;
    prev_addr = imem_req_addr;
    if (obs_rsp) void'(pend_q.pop_front());
    drv_redir = 1'b0;
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int x0, h0, n;
    logic seen;
    model_reset();
    #1;
    chk("init_req_valid", 32'(imem_req_valid), 32'd0);
    chk("init_inst_valid", 32'(inst_valid), 32'd0);
    chk("init_inst_pc", inst_pc, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: streaming from RESET_PC with 1-cycle memory
    lat = 1; drv_req_rdy = 1'b1; drv_inst_rdy = 1'b1;
    repeat (20) step();
    chk("t1_stream_progress", 32'(xfer_cnt >= 12), 32'd1);

    // 2: decode stalled -> exactly DEPTH requests, then drain in order and resume
    apply_reset();
    drv_req_rdy = 1'b1; drv_inst_rdy = 1'b0; h0 = hs_cnt;
    repeat (15) step();
    chk("t2_req_count", 32'(hs_cnt - h0), 32'd4);
    chk("t2_req_stalled", 32'(imem_req_valid), 32'd0);
    drv_inst_rdy = 1'b1; x0 = xfer_cnt; h0 = hs_cnt;
    repeat (4) step();
    chk("t2_drain4", 32'(xfer_cnt - x0), 32'd4);
    chk("t2_issue_resumed", 32'(hs_cnt > h0), 32'd1);

    // 3: two in flight at latency 3, then redirect
    lat = 3; n = 0;
    while (pend_q.size() < 2 && n < 20) begin step(); n++; end
    chk("t3_two_outstanding", 32'(pend_q.size() >= 2), 32'd1);
    drv_redir = 1'b1; drv_redir_pc = 32'h8000_0100;
    step();
    x0 = xfer_cnt; n = 0;
    while (xfer_cnt == x0 && n < 40) begin step(); n++; end
    chk("t3_first_pc", obs_xfer_pc, 32'h8000_0100);

    // 4: redirect coinciding with a response, unaligned target
    lat = 2; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        drv_redir = 1'b1; drv_redir_pc = 32'h8000_0102; seen = 1'b1;
      end
      step(); n++;
    end
    chk("t4_redirect_with_rsp", 32'(seen), 32'd1);
    n = 0;
    do begin step(); n++; end while (!obs_hs && n < 20);
    chk("t4_next_addr", obs_hs_addr, 32'h8000_0100);
    x0 = xfer_cnt; n = 0;
    while (xfer_cnt == x0 && n < 40) begin step(); n++; end
    chk("t4_first_pc", obs_xfer_pc, 32'h8000_0100);

    // 5: address wrap past 0xFFFFFFFC
    lat = 1; drv_redir = 1'b1; drv_redir_pc = 32'hFFFF_FFF8;
    step();
    seen = 1'b0; n = 0;
    while (!seen && n < 30) begin
      step(); n++;
      if (obs_hs && obs_hs_addr == 32'h0) seen = 1'b1;
    end
    chk("t5_wrap_to_zero", 32'(seen), 32'd1);
    repeat (6) step();

    // 6: response latency into an empty FIFO
    apply_reset();
    lat = 1; drv_req_rdy = 1'b0; drv_inst_rdy = 1'b1;
    repeat (2) step();
    chk("t6_req_pending", 32'(imem_req_valid), 32'd1);
    drv_req_rdy = 1'b1;
    step();
    chk("t6_single_req", 32'(obs_hs), 32'd1);
    drv_req_rdy = 1'b0; x0 = xfer_cnt;
    step();
    chk("t6_rsp_cycle", 32'(obs_rsp), 32'd1);
    chk("t6_same_cycle_valid", 32'(obs_inst_valid), 32'(BYP));
    step();
    chk("t6_next_cycle_valid", 32'(obs_inst_valid), 32'(!BYP));
    chk("t6_one_delivery", 32'(xfer_cnt - x0), 32'd1);

    // Randomized traffic with redirects, latency changes and one mid-run reset
    x0 = xfer_cnt;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      if (i == 1500) apply_reset();
      drv_req_rdy  = ($urandom_range(0, 3) != 0);
      drv_inst_rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) begin
        drv_redir = 1'b1;
        drv_redir_pc = 32'h8000_0000 | ($urandom() & 32'h0000_0FFF);
      end
      step();
    end
    chk("rand_progress", 32'(xfer_cnt - x0 > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
